stream_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream valid/ready stream (typically the left or right input port of a stream join) between NUM_IN upstream requesters. A requester holds the grant for at most BURST_LEN beats, or until its packet ends when packet locking is compiled in. Granted data passes through combinationally, so the block adds no beat latency once a grant is held. Grant changes cost one idle cycle.

---
 rtl/stream_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among NUM_IN requesters; data passes through combinationally.
// Optional STREAM_ARB_LOCK_EN: i_last of the granted requester also ends the grant.
module stream_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            i_valid,
  output logic [NUM_IN-1:0]            o_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_IN-1:0]            i_last,
  output logic                         o_valid,
  input  logic                         i_out_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_last,
  output logic                         o_grant_valid,
  output logic [ID_WIDTH-1:0]          o_grant_id
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    count_inc;

  logic                  active;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;
  logic                  burst_end;
  logic                  pick_vld;
  logic [ID_WIDTH-1:0]   pick_id;
  logic [ID_WIDTH-1:0]   cand;

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] p);
    if (p == ID_WIDTH'(NUM_IN - 1)) return '0;
    return p + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping around
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = rr_ptr_q;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!pick_vld && i_valid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant_id_q == ID_WIDTH'(k)) begin
        sel_valid = i_valid[k];
        sel_last  = i_last[k];
        sel_data  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset gates the outputs so no beat can move in the reset cycle
  assign active        = (state_q == GRANT) && !reset;
  assign o_valid       = active && sel_valid;
  assign o_data        = active ? sel_data : '0;
  assign o_last        = active && sel_last;
  assign o_grant_valid = active;
  assign o_grant_id    = grant_id_q;

  always_comb begin
    o_ready = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      o_ready[k] = active && (grant_id_q == ID_WIDTH'(k)) && i_out_ready;
    end
  end

  assign xfer      = o_valid && i_out_ready;
  assign count_inc = count_q + 1'b1;

`ifdef STREAM_ARB_LOCK_EN
  assign burst_end = (count_inc == CNT_W'(BURST_LEN)) || sel_last;
`else
  assign burst_end = (count_inc == CNT_W'(BURST_LEN));
`endif

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    if (state_q == IDLE) begin
      if (pick_vld) begin
        state_d    = GRANT;
        grant_id_d = pick_id;
        count_d    = '0;
      end
    end else if (xfer) begin
      count_d = count_inc;
      if (burst_end) begin
        state_d  = IDLE;
        rr_ptr_d = wrap_inc(grant_id_q);
        count_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: a cycle table for the single-requester cases plus
// hand-written sequences for contention, packet locking, reset and BURST_LEN=1.
module tb_stream_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  vld;
  logic [31:0] dat;
  logic [3:0]  lst;
  logic        ordy;

  logic [3:0]  o_ready;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_last;
  logic        o_gv;
  logic [1:0]  o_gid;

  logic [3:0]  o1_ready;
  logic        o1_valid;
  logic [7:0]  o1_data;
  logic        o1_last;
  logic        o1_gv;
  logic [1:0]  o1_gid;

  int n_checks = 0;
  int n_fail   = 0;

  stream_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk(clk), .reset(rst), .i_valid(vld), .o_ready(o_ready), .i_data(dat),
    .i_last(lst), .o_valid(o_valid), .i_out_ready(ordy), .o_data(o_data),
    .o_last(o_last), .o_grant_valid(o_gv), .o_grant_id(o_gid)
  );

  stream_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .reset(rst), .i_valid(vld), .o_ready(o1_ready), .i_data(dat),
    .i_last(lst), .o_valid(o1_valid), .i_out_ready(ordy), .o_data(o1_data),
    .o_last(o1_last), .o_grant_valid(o1_gv), .o_grant_id(o1_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        ordy;
    logic        e_vld;
    logic [3:0]  e_rdy;
    logic [7:0]  e_dat;
    logic        e_gv;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vld = 4'h0; dat = 32'h0; lst = 4'h0; ordy = 1'b0;
    @(negedge clk);
  endtask

  int beats;
  int bubbles;
  logic [1:0] exp_gid;

  initial begin
    rst = 1'b1; vld = 4'h0; dat = 32'h0; lst = 4'h0; ordy = 1'b0;

    vecs[0]  = '{1'b1, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 4'h4, 32'h00330000, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 4'h4, 32'h00330000, 1'b1, 1'b1, 4'h4, 8'h33, 1'b1, 2'd2};
    vecs[3]  = '{1'b0, 4'h4, 32'h00330000, 1'b1, 1'b1, 4'h4, 8'h33, 1'b1, 2'd2};
    vecs[4]  = '{1'b0, 4'h4, 32'h00330000, 1'b1, 1'b1, 4'h4, 8'h33, 1'b1, 2'd2};
    vecs[5]  = '{1'b0, 4'h4, 32'h00330000, 1'b1, 1'b1, 4'h4, 8'h33, 1'b1, 2'd2};
    vecs[6]  = '{1'b0, 4'h2, 32'h0000A500, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd2};
    vecs[7]  = '{1'b0, 4'h2, 32'h0000A500, 1'b0, 1'b1, 4'h0, 8'hA5, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 4'h2, 32'h0000A500, 1'b0, 1'b1, 4'h0, 8'hA5, 1'b1, 2'd1};
    vecs[9]  = '{1'b0, 4'h2, 32'h0000A500, 1'b0, 1'b1, 4'h0, 8'hA5, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 4'h2, 32'h0000A500, 1'b1, 1'b1, 4'h2, 8'hA5, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 4'h2, 32'h0000A500, 1'b1, 1'b1, 4'h2, 8'hA5, 1'b1, 2'd1};
    vecs[12] = '{1'b0, 4'h2, 32'h0000A500, 1'b1, 1'b1, 4'h2, 8'hA5, 1'b1, 2'd1};
    vecs[13] = '{1'b0, 4'h2, 32'h0000A500, 1'b1, 1'b1, 4'h2, 8'hA5, 1'b1, 2'd1};
    vecs[14] = '{1'b0, 4'h8, 32'h77000000, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd1};
    vecs[15] = '{1'b0, 4'h8, 32'h77000000, 1'b1, 1'b1, 4'h8, 8'h77, 1'b1, 2'd3};
    vecs[16] = '{1'b0, 4'h8, 32'h77000000, 1'b1, 1'b1, 4'h8, 8'h77, 1'b1, 2'd3};
    vecs[17] = '{1'b1, 4'h8, 32'h77000000, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd3};
    vecs[18] = '{1'b0, 4'h9, 32'h77000011, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0};
    vecs[19] = '{1'b0, 4'h9, 32'h77000011, 1'b1, 1'b1, 4'h1, 8'h11, 1'b1, 2'd0};

    repeat (2) @(posedge clk);

    // Single requesters: grant latency, bursts, stalls, mid-burst reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; vld = vecs[i].vld; dat = vecs[i].dat; ordy = vecs[i].ordy; lst = 4'h0;
      #1;
      chk($sformatf("v%0d o_valid", i), 32'(o_valid), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d o_ready", i), 32'(o_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d o_data", i),  32'(o_data),  32'(vecs[i].e_dat));
      chk($sformatf("v%0d grant_vld", i), 32'(o_gv),  32'(vecs[i].e_gv));
      chk($sformatf("v%0d grant_id", i), 32'(o_gid),  32'(vecs[i].e_gid));
      if (i >= 7 && i <= 9) chk($sformatf("v%0d stall_count", i), 32'(dut.count_q), 32'd0);
      if (i == 18) chk("post_reset rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    end

    // All four requesters contending: 0,1,2,3,0 in 4-beat bursts with one bubble each
    do_reset();
    rst = 1'b0; vld = 4'hF; dat = 32'hA3A2A1A0; ordy = 1'b1;
    beats = 0; bubbles = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (o_valid && ordy) begin
        exp_gid = 2'((beats / 4) % 4);
        chk($sformatf("rr beat%0d gid", beats), 32'(o_gid), 32'(exp_gid));
        chk($sformatf("rr beat%0d data", beats), 32'(o_data), 32'(8'hA0 + 8'(exp_gid)));
        beats++;
      end else begin
        bubbles++;
      end
      @(negedge clk);
    end
    chk("rr beats in 25 cycles", 32'(beats), 32'd20);
    chk("rr bubbles in 25 cycles", 32'(bubbles), 32'd5);

    // 2-beat packet from requester 0
    do_reset();
    rst = 1'b0; vld = 4'h1; dat = 32'h000000C0; ordy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      lst = (c == 2) ? 4'h1 : 4'h0;
      #1;
      if (c == 2) chk("lock o_last", 32'(o_last), 32'd1);
      if (c == 3) begin
`ifdef STREAM_ARB_LOCK_EN
        chk("lock grant released", 32'(o_gv), 32'd0);
        chk("lock rr_ptr", 32'(dut.rr_ptr_q), 32'd1);
`else
        chk("nolock grant held", 32'(o_gv), 32'd1);
        chk("nolock rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
`endif
      end
      @(negedge clk);
    end
    lst = 4'h0;

    // BURST_LEN=1: beat/bubble alternation between requesters 0 and 1
    do_reset();
    rst = 1'b0; vld = 4'h3; dat = 32'h0000B1B0; ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("bl1 c%0d o_valid", c), 32'(o1_valid), 32'(c % 2));
      if (c % 2 == 1) begin
        chk($sformatf("bl1 c%0d gid", c), 32'(o1_gid), 32'(((c - 1) / 2) % 2));
        chk($sformatf("bl1 c%0d data", c), 32'(o1_data), 32'(8'hB0 + 8'(((c - 1) / 2) % 2)));
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
